weighted_round_robin_arbiter: RTL and testbench

// - Round-robin arbiter for SIZE request channels with per-channel weights and a ready handshake.
// - A granted channel keeps the grant for up to WEIGHT+1 consecutive accepted transfers. Priority then moves past it.
// - Grant is held stable while the downstream side stalls.
// - Sits in front of shared buses or ports where bursty masters need bounded, weighted fairness.

---
 rtl/weighted_round_robin_arbiter.sv | 147 ++++++++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: a winner keeps the grant for up to weight+1 accepted transfers.
// Optional per-channel transfer counters under WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN.
module weighted_round_robin_arbiter #(
    parameter int unsigned SIZE         = 4,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    output logic [SIZE-1:0]              grant,
    output logic                         grant_valid,
    input  logic                         grant_ready,
    output logic [$clog2(SIZE)-1:0]      owner_index
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
    ,
    output logic [SIZE*16-1:0]           transfer_counts
`endif
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    typedef enum logic {ARBITRATE, LOCKED} phase_t;

    phase_t                  phase_q, phase_d;
    logic [IDX_W-1:0]        pointer_q, pointer_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] credits_q, credits_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic                    transfer;
    int unsigned             scan_pos;
    logic [WEIGHT_WIDTH-1:0] weight_of [SIZE];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (32'(idx) == SIZE - 1) ? '0 : idx + 1'b1;
    endfunction

    for (genvar g = 0; g < SIZE; g++) begin : g_weight
        assign weight_of[g] = weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // First requester at or after the pointer, wrapping modulo SIZE
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            scan_pos = 32'(pointer_q) + i;
            if (scan_pos >= SIZE) begin
                scan_pos = scan_pos - SIZE;
            end
            if (!win_found && requests[IDX_W'(scan_pos)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_pos);
            end
        end
    end

    assign win_weight = weight_of[win_idx];

    always_comb begin
        grant       = '0;
        owner_index = '0;
        if (!reset) begin
            if (phase_q == ARBITRATE) begin
                if (win_found) begin
                    grant       = SIZE'(1) << win_idx;
                    owner_index = win_idx;
                end
            end else if (requests[owner_q]) begin
                grant       = SIZE'(1) << owner_q;
                owner_index = owner_q;
            end
        end
    end

    assign grant_valid = |grant;
    assign transfer    = grant_valid & grant_ready;

    always_comb begin
        phase_d   = phase_q;
        pointer_d = pointer_q;
        owner_d   = owner_q;
        credits_d = credits_q;
        case (phase_q)
            ARBITRATE: begin
                if (win_found) begin
                    if (transfer && win_weight == '0) begin
                        pointer_d = next_idx(win_idx);
                    end else begin
                        // A stalled first beat does not consume credit
                        owner_d   = win_idx;
                        credits_d = transfer ? win_weight - 1'b1 : win_weight;
                        phase_d   = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!requests[owner_q]) begin
                    pointer_d = next_idx(owner_q);
                    phase_d   = ARBITRATE;
                end else if (transfer) begin
                    if (credits_q == '0) begin
                        pointer_d = next_idx(owner_q);
                        phase_d   = ARBITRATE;
                    end else begin
                        credits_d = credits_q - 1'b1;
                    end
                end
            end
            default: phase_d = ARBITRATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q   <= ARBITRATE;
            pointer_q <= '0;
            owner_q   <= '0;
            credits_q <= '0;
        end else begin
            phase_q   <= phase_d;
            pointer_q <= pointer_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
        end
    end

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
    // Saturating accepted-transfer counter per channel
    for (genvar g = 0; g < SIZE; g++) begin : g_stats
        logic [15:0] count_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                count_q <= '0;
            end else if (transfer && grant[g] && count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
        assign transfer_counts[g*16 +: 16] = count_q;
    end
`endif

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Self-checking bench for weighted_round_robin_arbiter: directed scenarios plus randomized
// traffic against a turn-budget reference model.
module tb_weighted_round_robin_arbiter;

    localparam int SIZE = 4;
    localparam int WW   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  requests;
    logic [15:0] weights;
    logic [3:0]  grant;
    logic        grant_valid;
    logic        grant_ready;
    logic [1:0]  owner_index;
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
    logic [63:0] transfer_counts;
`endif

    weighted_round_robin_arbiter #(.SIZE(SIZE), .WEIGHT_WIDTH(WW)) dut (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests),
        .weights     (weights),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .owner_index (owner_index)
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
        ,
        .transfer_counts (transfer_counts)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a turn holder with a budget of transfers left in its turn
    bit   m_in_turn;
    int   m_ptr, m_own, m_left;
    logic [3:0] exp_grant;
    logic [1:0] exp_owner;

    function automatic int m_scan();
        for (int k = 0; k < SIZE; k++) begin
            int c;
            c = (m_ptr + k) % SIZE;
            if (requests[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant();
        int c;
        if (reset) return 4'b0;
        if (!m_in_turn) begin
            c = m_scan();
            return (c < 0) ? 4'b0 : 4'(1 << c);
        end
        return requests[m_own] ? 4'(1 << m_own) : 4'b0;
    endfunction

    task automatic m_step();
        bit xfer;
        int c;
        if (reset) begin
            m_in_turn = 0; m_ptr = 0; m_own = 0; m_left = 0;
            return;
        end
        xfer = (m_grant() != 4'b0) && grant_ready;
        if (!m_in_turn) begin
            c = m_scan();
            if (c >= 0) begin
                m_own  = c;
                m_left = int'(weights[c*WW +: WW]) + 1 - (xfer ? 1 : 0);
                if (m_left == 0) m_ptr = (c + 1) % SIZE;
                else             m_in_turn = 1;
            end
        end else if (!requests[m_own]) begin
            m_ptr = (m_own + 1) % SIZE;
            m_in_turn = 0;
        end else if (xfer) begin
            m_left--;
            if (m_left == 0) begin
                m_ptr = (m_own + 1) % SIZE;
                m_in_turn = 0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] w, input logic rdy, input logic rst);
        @(negedge clock);
        requests = r; weights = w; grant_ready = rdy; reset = rst;
        #1;
        exp_grant = m_grant();
        exp_owner = 2'b0;
        for (int k = 0; k < SIZE; k++) if (exp_grant[k]) exp_owner = 2'(k);
    endtask

    task automatic test_reset();
        drive(4'b1111, 16'h0000, 1'b1, 1'b1);
        checks++;
        if (grant !== 4'b0 || grant_valid !== 1'b0 || owner_index !== 2'b0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b valid=%b owner=%0d, required 0000/0/0", grant, grant_valid, owner_index);
        end
        m_step();
        drive(4'b0000, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (grant !== 4'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_requests: grant=%b valid=%b, required 0000/0", grant, grant_valid);
        end
        m_step();
    endtask

    task automatic test_equal_weights();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 16'h0000, 1'b1, 1'b0);
            checks++;
            if (grant !== seq[i] || owner_index !== exp_owner) begin
                errors++;
                $display("FAIL equal_weights[%0d]: grant=%b owner=%0d, required %b/%0d", i, grant, owner_index, seq[i], exp_owner);
            end
            m_step();
        end
    endtask

    task automatic test_weighted();
        logic [3:0] seq [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0101, 16'h0002, 1'b1, 1'b0);
            checks++;
            if (grant !== seq[i] || grant !== exp_grant) begin
                errors++;
                $display("FAIL weighted[%0d]: grant=%b, required %b", i, grant, seq[i]);
            end
            m_step();
        end
    endtask

    task automatic test_stall();
        logic [3:0] req [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110};
        logic       rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] seq [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 6; i++) begin
            drive(req[i], 16'h0010, rdy[i], 1'b0);
            checks++;
            if (grant !== seq[i] || grant !== exp_grant) begin
                errors++;
                $display("FAIL stall_hold[%0d]: grant=%b, required %b", i, grant, seq[i]);
            end
            m_step();
        end
    endtask

    task automatic test_release();
        logic [3:0] req [4] = '{4'b1000, 4'b1001, 4'b0011, 4'b0011};
        logic [3:0] seq [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001};
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 4; i++) begin
            drive(req[i], 16'h3000, 1'b1, 1'b0);
            checks++;
            if (grant !== seq[i] || grant_valid !== (|seq[i])) begin
                errors++;
                $display("FAIL release[%0d]: grant=%b valid=%b, required %b", i, grant, grant_valid, seq[i]);
            end
            m_step();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] req [4] = '{4'b0100, 4'b0100, 4'b0110, 4'b0110};
        logic       rdy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       rst [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] seq [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0010};
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 4; i++) begin
            drive(req[i], 16'h0500, rdy[i], rst[i]);
            checks++;
            if (grant !== seq[i] || owner_index !== exp_owner) begin
                errors++;
                $display("FAIL reset_mid_burst[%0d]: grant=%b owner=%0d, required %b/%0d", i, grant, owner_index, seq[i], exp_owner);
            end
            m_step();
        end
    endtask

    task automatic test_random();
        logic [3:0]  r = 4'b0;
        logic [15:0] w = 16'h0000;
        logic [3:0]  last_xfer = 4'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            r = r & ~(last_xfer & 4'($urandom));
            if (i % 16 == 0) begin
                for (int k = 0; k < SIZE; k++) w[k*WW +: WW] = 4'($urandom_range(0, 3));
            end
            drive(r, w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
            checks++;
            if (grant !== exp_grant || grant_valid !== (|exp_grant) || owner_index !== exp_owner) begin
                errors++;
                $display("FAIL random[%0d]: grant=%b valid=%b owner=%0d, required %b/%b/%0d",
                         i, grant, grant_valid, owner_index, exp_grant, |exp_grant, exp_owner);
            end
            last_xfer = exp_grant & {4{grant_ready}};
            m_step();
        end
    endtask

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
    task automatic test_stats();
        drive(4'b0000, 16'h0000, 1'b1, 1'b1); m_step();
        for (int i = 0; i < 70000; i++) begin
            drive(4'b0001, 16'h0000, 1'b1, 1'b0);
            m_step();
        end
        @(negedge clock);
        checks++;
        if (transfer_counts[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: count0=%h, required ffff", transfer_counts[15:0]);
        end
        checks++;
        if (transfer_counts[63:16] !== 48'h0) begin
            errors++;
            $display("FAIL stats_others: counts=%h, required 0", transfer_counts[63:16]);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; requests = 4'b0; weights = 16'h0; grant_ready = 1'b0;
        m_in_turn = 0; m_ptr = 0; m_own = 0; m_left = 0;
        test_reset();
        test_equal_weights();
        test_weighted();
        test_stall();
        test_release();
        test_reset_mid_burst();
        test_random();
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
